// File: rtl/chip_bus_arbiter.sv
// Round-robin owner sequencer for the shared chip bus. Each tenure walks
// IDLE -> GRANT (settle) -> OWN (ready) -> TURN (bus released for one cycle).
// The TURN cycle keeps two inout data drivers from ever overlapping.
module chip_bus_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned IdW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CntW    = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] done_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic [IdW-1:0]     owner_id_o,
  output logic               timeout_o
);

  typedef enum logic [1:0] {StIdle, StGrant, StOwn, StTurn} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               ready_q, ready_d;
  logic               timeout_q, timeout_d;
  logic [IdW-1:0]     owner_q, owner_d;
  logic [IdW-1:0]     last_q, last_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic               pick_found;
  logic [IdW-1:0]     pick_idx;
  logic [IdW-1:0]     cand_idx;
  int unsigned        cand;

  logic               own_req;
  logic               own_done;
  logic               hold_hit;

  // Only the current owner's request/done bits matter; non-owner done is noise.
  assign own_req  = req_i[owner_q];
  assign own_done = done_i[owner_q];
  assign hold_hit = (cnt_q == CntW'(MAX_HOLD));

  // Round-robin pick: first set request searching upward from last+1, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(last_q) + i) % NUM_REQ;
      cand_idx = IdW'(cand);
      if (!pick_found && req_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state and registered-output logic for the tenure sequencer.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ready_d   = ready_q;
    timeout_d = 1'b0;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          last_d            = pick_idx;
          state_d           = StGrant;
        end
      end
      StGrant: begin
        if (own_req) begin
          ready_d = 1'b1;
          cnt_d   = CntW'(1);
          state_d = StOwn;
        end else begin
          // Owner withdrew during the settle cycle: release without ever going ready.
          grant_d = '0;
          state_d = StTurn;
        end
      end
      StOwn: begin
        if (own_done || !own_req || hold_hit) begin
          // Timeout only when the hold limit alone forced the release.
          timeout_d = hold_hit && !own_done && own_req;
          grant_d   = '0;
          ready_d   = 1'b0;
          cnt_d     = '0;
          state_d   = StTurn;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-high reset; reset mid-tenure skips TURN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
      owner_q   <= '0;
      last_q    <= IdW'(NUM_REQ - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant_o    = grant_q;
  assign ready_o    = ready_q;
  assign busy_o     = (state_q != StIdle);
  assign owner_id_o = owner_q;
  assign timeout_o  = timeout_q;

endmodule
